nand_apb_regs: RTL

//  APB3 slave register file that sits directly upstream of the NAND sequencing FSM.
//  It queues command bytes (up to 2) and address bytes (up to 5), and holds the transfer length.
//  It issues a one-cycle start pulse to the FSM and tracks busy/done/error status for software.

---
 rtl/nand_apb_regs.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/nand_apb_regs.sv
// rtl/nand_apb_regs.sv - APB3 register file feeding the NAND sequencing FSM
module nand_apb_regs #(
  parameter int CMD_DEPTH  = 2,
  parameter int ADDR_DEPTH = 5,
  parameter int LEN_W      = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETN,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [7:0]              PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [8*CMD_DEPTH-1:0]  C_Cmd,
  output logic [8*ADDR_DEPTH-1:0] C_Addr,
  output logic [LEN_W-1:0]        C_Length,
  output logic                    C_Start,
  input  logic                    C_Done,
  input  logic                    F_nRB
);

  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int ACW = $clog2(ADDR_DEPTH + 1);

  localparam logic [2:0] OFS_CMD    = 3'd0;
  localparam logic [2:0] OFS_ADDR   = 3'd1;
  localparam logic [2:0] OFS_LEN    = 3'd2;
  localparam logic [2:0] OFS_CTRL   = 3'd3;
  localparam logic [2:0] OFS_STATUS = 3'd4;

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic             r_start;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_cmd  [CMD_DEPTH];
  logic [7:0]       r_addr [ADDR_DEPTH];
  logic [CCW-1:0]   r_cmd_cnt;
  logic [ACW-1:0]   r_addr_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_rb_meta;
  logic             r_rb_sync;

  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_ofs;
  logic        w_busy;
  logic        w_cmd_full;
  logic        w_cmd_empty;
  logic        w_addr_full;
  logic        w_err_cond;
  logic        w_wr_err;
  logic        w_wr_ctrl;
  logic        w_cmd_push;
  logic        w_addr_push;
  logic        w_len_wr;
  logic        w_flush_ok;
  logic        w_start_ok;
  logic        w_clr;
  logic        w_done_ev;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_acc       = PSEL & PENABLE;
  assign w_wr        = w_acc & PWRITE;
  assign w_rd        = w_acc & ~PWRITE;
  assign w_ofs       = PADDR[4:2];
  assign w_busy      = (r_state == S_BUSY);
  assign w_cmd_full  = (r_cmd_cnt == CCW'(CMD_DEPTH));
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_addr_full = (r_addr_cnt == ACW'(ADDR_DEPTH));
  assign w_unused    = ^{PADDR[7:5], PADDR[1:0], PWDATA[31:8]};

  // Error decode for the access in flight; reads only fault on unmapped offsets
  always_comb begin
    w_err_cond = 1'b0;
    case (w_ofs)
      OFS_CMD:    w_err_cond = PWRITE & (w_busy | w_cmd_full);
      OFS_ADDR:   w_err_cond = PWRITE & (w_busy | w_addr_full);
      OFS_LEN:    w_err_cond = PWRITE & w_busy;
      OFS_CTRL:   w_err_cond = PWRITE & ((w_busy & (PWDATA[0] | PWDATA[1])) |
                                         (PWDATA[0] & (w_cmd_empty | PWDATA[1])));
      OFS_STATUS: w_err_cond = PWRITE;
      default:    w_err_cond = 1'b1;
    endcase
  end

  assign PSLVERR     = w_acc & w_err_cond;
  assign PREADY      = 1'b1;
  assign w_wr_err    = w_wr & w_err_cond;
  assign w_wr_ctrl   = w_wr & (w_ofs == OFS_CTRL);
  assign w_cmd_push  = w_wr & (w_ofs == OFS_CMD)  & ~w_err_cond;
  assign w_addr_push = w_wr & (w_ofs == OFS_ADDR) & ~w_err_cond;
  assign w_len_wr    = w_wr & (w_ofs == OFS_LEN)  & ~w_err_cond;
  // FLUSH still applies when paired with START; that pairing only raises err
  assign w_flush_ok  = w_wr_ctrl & PWDATA[1] & ~w_busy;
  assign w_start_ok  = w_wr_ctrl & PWDATA[0] & ~w_err_cond;
  assign w_clr       = w_wr_ctrl & PWDATA[2];
  assign w_done_ev   = w_busy & C_Done;

  // Start/busy FSM with registered start pulse and sticky done/err flags
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_BUSY;
            r_start <= 1'b1;
          end
        end
        S_BUSY: begin
          if (C_Done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // CLR acts first; a completion or a faulting write on the same edge wins
      r_done <= w_done_ev | (r_done & ~w_clr);
      r_err  <= w_wr_err  | (r_err  & ~w_clr);
    end
  end

  // Fill-only command/address queues, emptied by FLUSH or by completion
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cmd_cnt  <= '0;
      r_addr_cnt <= '0;
      for (int i = 0; i < CMD_DEPTH; i++)  r_cmd[i]  <= 8'h00;
      for (int i = 0; i < ADDR_DEPTH; i++) r_addr[i] <= 8'h00;
    end else if (w_done_ev || w_flush_ok) begin
      r_cmd_cnt  <= '0;
      r_addr_cnt <= '0;
      for (int i = 0; i < CMD_DEPTH; i++)  r_cmd[i]  <= 8'h00;
      for (int i = 0; i < ADDR_DEPTH; i++) r_addr[i] <= 8'h00;
    end else begin
      if (w_cmd_push) begin
        for (int i = 0; i < CMD_DEPTH; i++)
          if (r_cmd_cnt == CCW'(i)) r_cmd[i] <= PWDATA[7:0];
        r_cmd_cnt <= r_cmd_cnt + CCW'(1);
      end
      if (w_addr_push) begin
        for (int i = 0; i < ADDR_DEPTH; i++)
          if (r_addr_cnt == ACW'(i)) r_addr[i] <= PWDATA[7:0];
        r_addr_cnt <= r_addr_cnt + ACW'(1);
      end
    end
  end

  // Transfer length; survives completion so software can reuse it
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_len <= '0;
    else if (w_len_wr) r_len <= PWDATA[LEN_W-1:0];
  end

  // Two-flop synchroniser for the NAND ready/busy_n pin
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rb_meta <= 1'b1;
      r_rb_sync <= 1'b1;
    end else begin
      r_rb_meta <= F_nRB;
      r_rb_sync <= r_rb_meta;
    end
  end

  // Pack the queue slots toward the FSM, slot 0 in the low byte
  always_comb begin
    C_Cmd  = '0;
    C_Addr = '0;
    for (int i = 0; i < CMD_DEPTH; i++)  C_Cmd[8*i +: 8]  = r_cmd[i];
    for (int i = 0; i < ADDR_DEPTH; i++) C_Addr[8*i +: 8] = r_addr[i];
  end

  assign C_Length = r_len;
  assign C_Start  = r_start;

  // Status word assembly
  always_comb begin
    w_status       = '0;
    w_status[0]    = w_busy;
    w_status[1]    = r_done;
    w_status[2]    = r_err;
    w_status[3]    = r_rb_sync;
    w_status[5:4]  = 2'(r_cmd_cnt);
    w_status[10:8] = 3'(r_addr_cnt);
  end

  // Read data mux, driven only during a read access phase
  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_ofs)
        OFS_CMD:    PRDATA = 32'(r_cmd[0]);
        OFS_ADDR:   PRDATA = 32'(r_addr[0]);
        OFS_LEN:    PRDATA = 32'(r_len);
        OFS_STATUS: PRDATA = w_status;
        default:    PRDATA = '0;
      endcase
    end
  end

endmodule
